// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffer pipeline stage with flush and stall counter
module pipe_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the occupancy count, so occupancy is a straight copy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;

  // Handshake qualifiers, built from the state flops rather than from the
  // output ports so no combinational loop forms through in_ready/out_valid.
  logic push;
  logic pop;
  logic stall;
  logic stall_sat;

  // Datapath load enables; at most one source per register per cycle.
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign push      = in_valid  & (state != ST_FULL);
  assign pop       = out_ready & (state != ST_EMPTY);
  assign stall     = ~out_ready & (state != ST_EMPTY);
  assign stall_sat = &stall_q;

  // State register; reset empties the stage immediately, independent of clk.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; flush overrides any push/pop in the same cycle.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) state_nxt = ST_HALF;
        end
        ST_HALF: begin
          if (push && !pop)      state_nxt = ST_FULL;
          else if (!push && pop) state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (pop) state_nxt = ST_HALF;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Status outputs decoded purely from the state flops.
  always_comb begin
    in_ready  = (state != ST_FULL);
    out_valid = (state != ST_EMPTY);
    occupancy = state;
  end

  // Datapath steering: which register captures what on this edge.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (!flush) begin
      case (state)
        ST_EMPTY: begin
          load_main_in = push;
        end
        ST_HALF: begin
          // Push alone parks the new beat behind main; push with pop
          // replaces the departing head directly.
          load_skid_in = push & ~pop;
          load_main_in = push & pop;
        end
        ST_FULL: begin
          load_main_skid = pop;
        end
        default: begin
          load_main_in = 1'b0;
        end
      endcase
    end
  end

  // Main and skid registers; a drained stage keeps the last head on out_data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_q <= PRESET_VAL;
      skid_q <= PRESET_VAL;
    end else if (flush) begin
      main_q <= PRESET_VAL;
      skid_q <= PRESET_VAL;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data;
      end
    end
  end

  // Saturating stall counter; counts through flush, cleared only by reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
    end else if (stall && !stall_sat) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_data  = main_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int          DATA_W    = 32;
  localparam logic [31:0] PRESET    = 32'hDEAD_BEEF;
  localparam int          CNT_W     = 4;
  localparam int          STALL_MAX = 15;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;
  int emitted  = 0;

  // Reference model: an ordered list of held beats, the value expected on
  // out_data, and a saturating stall count.
  logic [31:0] m_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] m_data  = PRESET;
  int          m_stall = 0;
  bit          m_vld;
  bit          m_rdy;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .PRESET_VAL(PRESET),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every accepted edge; reset clears it at once.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_q.delete();
      sb_q.delete();
      m_data  = PRESET;
      m_stall = 0;
    end else begin
      m_vld = (m_q.size() > 0);
      m_rdy = (m_q.size() < 2);
      if (m_vld && !out_ready && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        m_q.delete();
        sb_q.delete();
        m_data = PRESET;
      end else begin
        if (m_vld && out_ready) void'(m_q.pop_front());
        if (in_valid && m_rdy) begin
          m_q.push_back(in_data);
          sb_q.push_back(in_data);
        end
        if (m_q.size() > 0) m_data = m_q[0];
      end
    end
  end

  // Monitor: status against the model, delivered beats against the scoreboard.
  always @(negedge clk) begin
    check("in_ready",  {31'd0, in_ready},  (m_q.size() < 2) ? 32'd1 : 32'd0);
    check("out_valid", {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
    check("occupancy", {30'd0, occupancy}, m_q.size());
    check("stall_cnt", {28'd0, stall_cnt}, m_stall);
    check("out_data",  out_data, m_data);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_beat actual=%0h required=no_beat at %0t", out_data, $time);
      end else begin
        emitted++;
        check("sb_order", out_data, sb_q.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge: asserts reset mid-cycle, holds it
  // across one edge, releases it mid-cycle.
  task automatic reset_pulse();
    #2;
    arst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    check("rst_out_data",  out_data, PRESET);
    @(posedge clk);
    #1;
    check("rst_hold_occupancy", {30'd0, occupancy}, 32'd0);
    #2;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("init_out_valid", {31'd0, out_valid}, 32'd0);
    check("init_out_data",  out_data, PRESET);
    #11;
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming
    step(1'b1, 32'h11, 1'b1, 1'b0);
    check("stream_d0", out_data, 32'h11);
    check("stream_occ", {30'd0, occupancy}, 32'd1);
    step(1'b1, 32'h22, 1'b1, 1'b0);
    check("stream_d1", out_data, 32'h22);
    step(1'b1, 32'h33, 1'b1, 1'b0);
    check("stream_d2", out_data, 32'h33);
    check("stream_rdy", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_hold_data", out_data, 32'h33);

    // Backpressure
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_occ", {30'd0, occupancy}, 32'd2);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    check("bp_head", out_data, 32'hA);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_second", out_data, 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_third", out_data, 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full with a concurrent push
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h5, 1'b0, 1'b1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_data",  out_data, PRESET);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_no_beat", {31'd0, out_valid}, 32'd0);

    // Stall counter saturation
    step(1'b1, 32'h7, 1'b0, 1'b0);
    repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_cnt", {28'd0, stall_cnt}, 32'd15);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("sat_hold", {28'd0, stall_cnt}, 32'd15);

    // Asynchronous reset while full
    step(1'b1, 32'h8, 1'b0, 1'b0);
    check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    reset_pulse();

    // Randomized traffic with occasional flushes and reset pulses
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        reset_pulse();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0);
      end
    end

    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_sb_empty", sb_q.size(), 32'd0);
    check("beats_emitted", (emitted > 20) ? 32'd1 : 32'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits.
REQ-002 SHALL have parameter PRESET_VAL, default 0: value loaded into both data registers on reset and on flush.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 SHALL have port clk  input  1: clock, rising edge.
REQ-005 SHALL have port arst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1: synchronous pipeline flush (bubble insert).
REQ-007 SHALL have port in_valid  input  1: upstream offers in_data.
REQ-008 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-009 SHALL have port in_ready  output  1: stage can accept a beat.
REQ-010 SHALL have port out_valid  output  1: out_data holds a valid beat.
REQ-011 SHALL have port out_data  output  DATA_W: downstream payload.
REQ-012 SHALL have port out_ready  input  1: downstream accepts the beat.
REQ-013 SHALL have port occupancy  output  2: number of beats held, 0..2.
REQ-014 SHALL have port stall_cnt  output  CNT_W: cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL hold beats in a main register (drives out_data) and a skid register; state EMPTY(0), HALF(1) or FULL(2), stored in flops.
REQ-016 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), decoded from state flops only, with no combinational path from in_valid or out_ready.
REQ-017 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising clk edge.
REQ-018 EMPTY: on push, SHALL load main with in_data and go to HALF; otherwise SHALL stay EMPTY.
REQ-019 HALF: push without pop SHALL load skid and go to FULL; pop without push SHALL go to EMPTY; push with pop SHALL load main with in_data and stay in HALF; neither SHALL hold.
REQ-020 FULL: pop SHALL move skid into main and go to HALF; without pop SHALL hold both registers.
REQ-021 SHALL deliver beats in acceptance order, with no loss and no duplication.
REQ-022 SHALL make a beat pushed into EMPTY visible on out_data with out_valid=1 one cycle after acceptance.
REQ-023 SHALL leave out_data unchanged on the HALF->EMPTY transition.
REQ-024 SHALL drive occupancy equal to the state encoding.
REQ-025 flush=1 SHALL take priority over push and pop in the same cycle: next state EMPTY, main and skid set to PRESET_VAL, and any concurrent push discarded.
REQ-026 SHALL drive in_ready=1 in the cycle after a flush.
REQ-027 SHALL increment stall_cnt by 1 per cycle with out_valid=1 and out_ready=0, including during a flush cycle.
REQ-028 SHALL saturate stall_cnt at 2^CNT_W-1 with no wrap.
REQ-029 SHALL clear stall_cnt only on reset, not on flush.
REQ-030 SHALL ignore in_data and in_valid while in_ready=0.

Reset
REQ-031 While arst_n=0, SHALL drive state=EMPTY, in_ready=1, out_valid=0, out_data=PRESET_VAL, skid=PRESET_VAL, occupancy=0 and stall_cnt=0, independent of clk.
REQ-032 SHALL resume normal operation at the first rising clk edge after arst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL discard held beats immediately.

Verification
REQ-034 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values appear on out_data one cycle later each, occupancy stays 1, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA and 0xB accepted, in_ready=0 after the second push, 0xC held upstream; then out_ready=1 -> output order 0xA,0xB,0xC.
REQ-036 Flush: FULL with flush=1, in_valid=1 and in_data=0x5 in the same cycle -> next cycle out_valid=0, out_data=PRESET_VAL, occupancy=0, 0x5 never emitted.
REQ-037 Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds at 15.
REQ-038 Async reset: assert arst_n=0 between clk edges while FULL -> out_valid=0, in_ready=1, occupancy=0 and stall_cnt=0 immediately, before the next edge.
